// File: rtl/sipo_deserializer_pkg.sv
// Shared definitions for the SIPO deserializer: FSM state encoding and counter sizing.
package sipo_deserializer_pkg;

    typedef logic [0:0] state_t;

    localparam state_t StIdle  = 1'b0;
    localparam state_t StShift = 1'b1;

    // Width needed to hold a bit count in the range 0..width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/deser_out_stage.sv
// Output register of the deserializer: valid/ready handshake and sticky overrun flag.
module deser_out_stage #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] word,
    input  logic             word_done,
    input  logic             out_ready,
    input  logic             clr_overrun,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             transfer;
    logic             accept;
    logic             drop;

    assign transfer = valid_q & out_ready;
    // A new word fits if the register is empty or is being emptied on this edge.
    assign accept   = word_done & (~valid_q | out_ready);
    assign drop     = word_done & valid_q & ~out_ready;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (accept) begin
            data_d  = word;
            valid_d = 1'b1;
        end else if (transfer) begin
            valid_d = 1'b0;
        end

        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign parallel_out = data_q;
    assign out_valid    = valid_q;
    assign overrun      = overrun_q;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out receiver: collects qualified serial bits into WIDTH-bit words.
module sipo_deserializer
    import sipo_deserializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          serial_in,
    input  logic                          bit_valid,
    input  logic                          frame_sync,
    input  logic                          out_ready,
    input  logic                          clr_overrun,
    output logic [WIDTH-1:0]              parallel_out,
    output logic                          out_valid,
    output logic                          overrun,
    output logic [cnt_width(WIDTH)-1:0]   bit_count
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 16) begin : gen_width_check
        $error("sipo_deserializer: WIDTH must be in 2..16");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] first_bit;
    logic             last_bit;
    logic             word_done;
    logic [WIDTH-1:0] word;

    // Shift direction decides where the first received bit ends up.
    always_comb begin
        if (MSB_FIRST) begin
            shifted   = {shreg_q[WIDTH-2:0], serial_in};
            first_bit = {{(WIDTH-1){1'b0}}, serial_in};
        end else begin
            shifted   = {serial_in, shreg_q[WIDTH-1:1]};
            first_bit = {serial_in, {(WIDTH-1){1'b0}}};
        end
    end

    assign last_bit = (state_q == StShift) && (cnt_q == LastIdx);

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        word_done = 1'b0;
        word      = shifted;

        if (frame_sync) begin
            // Realignment wins over completion: the sampled bit starts a new word.
            if (bit_valid) begin
                shreg_d = first_bit;
                cnt_d   = CntW'(1);
                state_d = StShift;
            end else begin
                shreg_d = '0;
                cnt_d   = '0;
                state_d = StIdle;
            end
        end else if (bit_valid) begin
            if (last_bit) begin
                word_done = 1'b1;
                shreg_d   = '0;
                cnt_d     = '0;
                state_d   = StIdle;
            end else begin
                shreg_d = shifted;
                cnt_d   = cnt_q + CntW'(1);
                state_d = StShift;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bit_count = cnt_q;

    deser_out_stage #(
        .WIDTH (WIDTH)
    ) u_out_stage (
        .clk          (clk),
        .rst_n        (rst_n),
        .word         (word),
        .word_done    (word_done),
        .out_ready    (out_ready),
        .clr_overrun  (clr_overrun),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .overrun      (overrun)
    );

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Serial-in parallel-out receive stage that sits directly downstream of the 4-bit PISO shift register.
- Samples the PISO serial output one bit per qualified clock and reassembles WIDTH-bit words.
- Presents each word on a registered valid/ready output port with sticky overrun reporting.
- Frame re-alignment is done through a frame_sync input.

Parameters:
- WIDTH, 4, bits per word; legal range 2..16.
- MSB_FIRST, 1, 1 = first received bit lands in parallel_out[WIDTH-1] (matches PISO shift order); 0 = first bit lands in parallel_out[0].

Ports:
- clk  input  1  rising-edge clock, the single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- serial_in  input  1  serial data, driven from the PISO serial_out.
- bit_valid  input  1  serial_in is sampled on the rising clk edge where this is 1 (driven from the PISO shift_en).
- frame_sync  input  1  discard any partial word; the bit sampled in this same cycle, if any, is bit 0 of a new word.
- out_ready  input  1  consumer accepts parallel_out.
- clr_overrun  input  1  clears the overrun flag.
- parallel_out  output  WIDTH  assembled word; held stable while out_valid=1.
- out_valid  output  1  parallel_out holds an unconsumed word.
- overrun  output  1  sticky; a completed word was dropped.
- bit_count  output  $clog2(WIDTH+1)  number of bits collected in the current partial word.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - state=IDLE, shift register=0, bit_count=0, parallel_out=0, out_valid=0, overrun=0.
  - Reset asserted mid-word discards the partial word and any pending output word.
- FSM states:
  - IDLE: bit_count=0.
    - bit_valid=1 -> capture bit 0, bit_count=1, go to SHIFT.
  - SHIFT: 1 <= bit_count <= WIDTH-1.
    - bit_valid=1 -> capture the bit, bit_count+1.
    - When the captured bit is bit WIDTH-1 -> word complete, bit_count=0, go to IDLE.
    - bit_valid=0 -> hold state; there is no timeout.
- Bit placement:
  - MSB_FIRST=1: shift left, new bit enters at LSB; after WIDTH bits the first bit sits at [WIDTH-1].
  - MSB_FIRST=0: shift right, new bit enters at MSB.
- Word completion:
  - Completion at edge N loads the word into parallel_out at edge N, so out_valid=1 from the cycle following the last sampled bit (latency 1 clk).
  - Back-to-back words with bit_valid continuously high are supported, with no bubble cycle.
- Output handshake:
  - A transfer occurs at an edge where out_valid=1 and out_ready=1.
  - After a transfer, out_valid clears unless a new word completes on the same edge; in that case parallel_out reloads and out_valid stays 1.
  - out_ready is ignored while out_valid=0.
  - parallel_out must not change while out_valid=1 and no transfer occurs.
- Overrun:
  - A word completing while out_valid=1 and out_ready=0 is dropped and overrun is set.
  - parallel_out keeps the older word.
  - overrun stays set until clr_overrun=1.
  - If set and clear coincide at the same edge, set wins.
- frame_sync:
  - Forces bit_count to 0 and clears the partial word.
  - If bit_valid=1 in the same cycle, that bit becomes bit 0 (bit_count=1, SHIFT).
  - Otherwise go to IDLE.
  - Has no effect on out_valid, parallel_out or overrun.
  - frame_sync coinciding with what would be the final bit: the bit is treated as bit 0, and no word completes.
- Width: bit_count never exceeds WIDTH-1 when observed; there is no wrap beyond WIDTH.

Decomposition:
- Shared package: state enum (IDLE, SHIFT), and the function computing the bit_count width from WIDTH.
- One sub-module: deser_out_stage. It holds the output register and the valid/ready/overrun logic, and takes a word plus a word_done strobe from the shift/FSM core.

Test Plan:
- Reset check: hold rst_n=0 with toggling inputs -> all outputs 0. Assert rst_n=0 after 2 bits of a word, then release -> bit_count=0 and the next 4 bits form a fresh word.
- Bit order: WIDTH=4, MSB_FIRST=1, stream 1,0,1,1 with bit_valid=1 and out_ready=1 -> parallel_out=4'b1011, out_valid high 1 cycle after the 4th bit. Same stream with MSB_FIRST=0 -> 4'b1101.
- Gaps and streaming: bit_valid gapped 1,0,0,1,... -> no change while bit_valid=0. Two words 4'hA then 4'h5 back-to-back with out_ready=1 -> two consecutive valid transfers, no bubble.
- Overrun: out_ready=0, send 4'h3 then 4'hC -> parallel_out stays 4'h3 and overrun=1. Raise out_ready -> 4'h3 consumed. clr_overrun -> overrun=0.
- frame_sync: send bits 1,1 then frame_sync with bit 0, then bits 1,0,1 -> parallel_out=4'b0101 and bit_count sequence 1,2,1,2,3,0.
- Simultaneous events: transfer on the same edge a new word completes -> out_valid stays 1 with the new word. Also check overrun set coinciding with clr_overrun -> overrun=1.
